// File: rtl/tick_time_keeper_pkg.sv
// Shared widths, limits and time helpers for the tick time keeper.
package tick_time_keeper_pkg;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

  typedef struct packed {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
  } time_t;

  localparam time_t TIME_ZERO = '{hr: '0, min: '0, sec: '0};
  localparam time_t TIME_LAST = '{hr: HR_MAX, min: MIN_MAX, sec: SEC_MAX};

  // True when every field is inside its legal range.
  function automatic logic time_valid(input time_t t);
    return (t.hr <= HR_MAX) && (t.min <= MIN_MAX) && (t.sec <= SEC_MAX);
  endfunction

  // One-second advance with seconds -> minutes -> hours carry and day rollover.
  function automatic time_t time_inc(input time_t t);
    time_t r;
    r = t;
    if (t.sec == SEC_MAX) begin
      r.sec = '0;
      if (t.min == MIN_MAX) begin
        r.min = '0;
        r.hr  = (t.hr == HR_MAX) ? '0 : t.hr + 5'd1;
      end else begin
        r.min = t.min + 6'd1;
      end
    end else begin
      r.sec = t.sec + 6'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_time_keeper_if.sv
// Load request and time/status bundle between the time keeper and its user.
interface tick_time_keeper_if;
  import tick_time_keeper_pkg::*;

  logic             load;
  logic [HR_W-1:0]  load_hr;
  logic [MIN_W-1:0] load_min;
  logic [SEC_W-1:0] load_sec;
  logic [HR_W-1:0]  hours;
  logic [MIN_W-1:0] minutes;
  logic [SEC_W-1:0] seconds;
  logic             tick;
  logic             day_wrap;
  logic             load_ack;
  logic             load_err;

  // User side: issues loads, observes the time.
  modport master (
    output load, load_hr, load_min, load_sec,
    input  hours, minutes, seconds, tick, day_wrap, load_ack, load_err
  );

  // Time keeper side.
  modport slave (
    input  load, load_hr, load_min, load_sec,
    output hours, minutes, seconds, tick, day_wrap, load_ack, load_err
  );
endinterface

// File: rtl/tick_sync.sv
// Synchronizes the divided slow clock into clk and emits one pulse per
// rising edge, but only after a genuine low level has been observed.
module tick_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic [STAGES-1:0] sync_r;
  logic [STAGES-1:0] fill_r;
  logic              sync_q;
  logic              prev_q;
  logic              armed;

  assign sync_q = sync_r[STAGES-1];

  // Synchronizer chain, fill tracker, edge register, arming and pulse.
  // fill_r marks when sync_q reflects sampled input instead of reset zeros,
  // so a slow_clk held high across reset cannot arm and fire a false tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
      fill_r <= '0;
      prev_q <= 1'b0;
      armed  <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value of its neighbour, which is what makes this a shift chain.
      sync_r <= {sync_r[STAGES-2:0], async_in};
      fill_r <= {fill_r[STAGES-2:0], 1'b1};
      prev_q <= sync_q;
      if (fill_r[STAGES-1] && !sync_q) armed <= 1'b1;
      pulse  <= sync_q & ~prev_q & armed;
    end
  end

endmodule

// File: rtl/tick_time_keeper.sv
// Time-of-day keeper advanced by synchronized slow_clk ticks, with a
// range-checked load port and day rollover indication.
module tick_time_keeper
  import tick_time_keeper_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                slow_clk,
  tick_time_keeper_if.slave   bus
);

  logic  tick;
  time_t cur;
  time_t nxt;
  logic  nxt_wrap;
  time_t ld;
  logic  ld_ok;
  logic  ack_r;
  logic  err_r;
  logic  wrap_r;

  tick_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (slow_clk),
    .pulse    (tick)
  );

  assign ld    = '{hr: bus.load_hr, min: bus.load_min, sec: bus.load_sec};
  assign ld_ok = time_valid(ld);

  // Next time and rollover flag for a tick-driven advance.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    nxt      = cur;
    nxt_wrap = 1'b0;
    if (tick) begin
      nxt      = time_inc(cur);
      nxt_wrap = (cur == TIME_LAST);
    end
  end

  // Time registers and status pulses; any load request overrides the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur    <= TIME_ZERO;
      ack_r  <= 1'b0;
      err_r  <= 1'b0;
      wrap_r <= 1'b0;
    end else begin
      ack_r  <= 1'b0;
      err_r  <= 1'b0;
      wrap_r <= 1'b0;
      if (bus.load) begin
        if (ld_ok) begin
          cur   <= ld;
          ack_r <= 1'b1;
        end else begin
          err_r <= 1'b1;
        end
      end else begin
        cur    <= nxt;
        wrap_r <= nxt_wrap;
      end
    end
  end

  assign bus.hours    = cur.hr;
  assign bus.minutes  = cur.min;
  assign bus.seconds  = cur.sec;
  assign bus.tick     = tick;
  assign bus.day_wrap = wrap_r;
  assign bus.load_ack = ack_r;
  assign bus.load_err = err_r;

endmodule

// File: tb/tb_tick_time_keeper.sv
// Directed bench for tick_time_keeper: load table plus latency, rollover,
// load/tick collision, reset and long-count sequences.
module tb_tick_time_keeper;

  logic clk;
  logic rst;
  logic slow_clk;
  int   total;
  int   bad;
  int   n_tick;
  int   n_wrap;
  int   t_seen;

  tick_time_keeper_if bus ();

  tick_time_keeper #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .slow_clk (slow_clk),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] hr;
    logic [5:0] mn;
    logic [5:0] sc;
    logic       ack;
    logic       err;
    int         hms;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int hms_now();
    return int'(bus.hours) * 10000 + int'(bus.minutes) * 100 + int'(bus.seconds);
  endfunction

  function automatic int pulses_now();
    return int'(bus.tick) + int'(bus.day_wrap) + int'(bus.load_ack) + int'(bus.load_err);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    bus.load     = 1'b1;
    bus.load_hr  = h;
    bus.load_min = m;
    bus.load_sec = s;
    step();
    bus.load = 1'b0;
  endtask

  task automatic run_periods(input int n);
    for (int i = 0; i < n; i++) begin
      slow_clk = 1'b1;
      repeat (4) begin
        step();
        n_tick += int'(bus.tick);
        n_wrap += int'(bus.day_wrap);
      end
      slow_clk = 1'b0;
      repeat (4) begin
        step();
        n_tick += int'(bus.tick);
        n_wrap += int'(bus.day_wrap);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{5'd10, 6'd20, 6'd30, 1'b1, 1'b0, 102030};
    vecs[1] = '{5'd24, 6'd0,  6'd0,  1'b0, 1'b1, 102030};
    vecs[2] = '{5'd12, 6'd60, 6'd0,  1'b0, 1'b1, 102030};
    vecs[3] = '{5'd0,  6'd0,  6'd60, 1'b0, 1'b1, 102030};
    vecs[4] = '{5'd23, 6'd59, 6'd59, 1'b1, 1'b0, 235959};
    vecs[5] = '{5'd31, 6'd63, 6'd63, 1'b0, 1'b1, 235959};
    vecs[6] = '{5'd0,  6'd0,  6'd0,  1'b1, 1'b0, 0};
    vecs[7] = '{5'd23, 6'd0,  6'd59, 1'b1, 1'b0, 230059};
    vecs[8] = '{5'd0,  6'd59, 6'd0,  1'b1, 1'b0, 5900};

    rst          = 1'b1;
    slow_clk     = 1'b0;
    bus.load     = 1'b0;
    bus.load_hr  = '0;
    bus.load_min = '0;
    bus.load_sec = '0;

    // Reset state.
    repeat (3) step();
    check("reset_time", hms_now(), 0);
    check("reset_pulses", pulses_now(), 0);
    rst = 1'b0;
    step();
    check("post_reset_pulses", pulses_now(), 0);

    // Tick latency: slow_clk rises, tick exactly 3 cycles later, seconds next.
    repeat (8) step();
    slow_clk = 1'b1;
    t_seen = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      if (i < 3) t_seen += int'(bus.tick);
    end
    check("tick_early", t_seen, 0);
    check("tick_at_latency", int'(bus.tick), 1);
    check("sec_before_update", hms_now(), 0);
    step();
    check("sec_after_tick", hms_now(), 1);
    t_seen = int'(bus.tick);
    repeat (6) begin
      step();
      t_seen += int'(bus.tick);
    end
    check("no_repeat_tick_high", t_seen, 0);
    check("time_held_high", hms_now(), 1);
    slow_clk = 1'b0;
    repeat (4) step();

    // Load table.
    for (int i = 0; i < 9; i++) begin
      do_load(vecs[i].hr, vecs[i].mn, vecs[i].sc);
      check($sformatf("vec%0d_ack", i), int'(bus.load_ack), int'(vecs[i].ack));
      check($sformatf("vec%0d_err", i), int'(bus.load_err), int'(vecs[i].err));
      check($sformatf("vec%0d_wrap", i), int'(bus.day_wrap), 0);
      check($sformatf("vec%0d_time", i), hms_now(), vecs[i].hms);
      step();
      check($sformatf("vec%0d_single", i), int'(bus.load_ack) + int'(bus.load_err), 0);
    end

    // Rollover through midnight.
    do_load(5'd23, 6'd59, 6'd58);
    check("pre_wrap_load", hms_now(), 235958);
    n_tick = 0;
    n_wrap = 0;
    run_periods(1);
    check("wrap_step1_time", hms_now(), 235959);
    check("wrap_step1_nowrap", n_wrap, 0);
    slow_clk = 1'b1;
    repeat (3) step();
    check("wrap_tick", int'(bus.tick), 1);
    check("wrap_before", int'(bus.day_wrap), 0);
    step();
    check("wrap_time", hms_now(), 0);
    check("wrap_pulse", int'(bus.day_wrap), 1);
    step();
    check("wrap_pulse_single", int'(bus.day_wrap), 0);
    slow_clk = 1'b0;
    repeat (4) step();

    // Load in the same cycle as tick: load wins, no increment.
    slow_clk = 1'b1;
    repeat (3) step();
    check("collide_tick", int'(bus.tick), 1);
    do_load(5'd5, 6'd6, 6'd7);
    check("collide_time", hms_now(), 50607);
    check("collide_ack", int'(bus.load_ack), 1);
    step();
    check("collide_hold", hms_now(), 50607);
    slow_clk = 1'b0;
    repeat (4) step();

    // One hour of ticks from midnight.
    do_load(5'd0, 6'd0, 6'd0);
    check("zero_load_nowrap", int'(bus.day_wrap), 0);
    check("zero_load_ack", int'(bus.load_ack), 1);
    n_tick = 0;
    n_wrap = 0;
    run_periods(3600);
    check("hour_ticks", n_tick, 3600);
    check("hour_wraps", n_wrap, 0);
    check("hour_time", hms_now(), 10000);

    // Reset concurrent with a valid load.
    bus.load     = 1'b1;
    bus.load_hr  = 5'd10;
    bus.load_min = 6'd10;
    bus.load_sec = 6'd10;
    rst          = 1'b1;
    step();
    check("rst_load_time", hms_now(), 0);
    check("rst_load_pulses", pulses_now(), 0);
    bus.load = 1'b0;
    rst      = 1'b0;
    step();
    check("rst_release_pulses", pulses_now(), 0);

    // slow_clk high across reset release: no tick until a fresh 0->1.
    rst      = 1'b1;
    slow_clk = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    t_seen = int'(bus.tick);
    repeat (9) begin
      step();
      t_seen += int'(bus.tick);
    end
    check("high_release_no_tick", t_seen, 0);
    check("high_release_time", hms_now(), 0);
    slow_clk = 1'b0;
    repeat (4) step();
    slow_clk = 1'b1;
    repeat (2) step();
    check("rearm_early", int'(bus.tick), 0);
    step();
    check("rearm_tick", int'(bus.tick), 1);
    step();
    check("rearm_time", hms_now(), 1);
    slow_clk = 1'b0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_time_keeper.md
TICK_TIME_KEEPER -- requirements
Module: tick_time_keeper

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops applied to slow_clk; legal range 2..4.
REQ-002 clk  input  1  system clock; all logic on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 slow_clk  input  1  divided toggle clock from the divider, sampled as data in the clk domain.
REQ-005 load  input  1  single-cycle request to overwrite the time.
REQ-006 load_hr / load_min / load_sec  input  5 / 6 / 6  binary values captured when load=1.
REQ-007 hours / minutes / seconds  output  5 / 6 / 6  current time, binary, registered.
REQ-008 tick  output  1  one-cycle pulse per accepted slow_clk rising edge.
REQ-009 day_wrap  output  1  one-cycle pulse when the time rolls from 23:59:59 to 00:00:00.
REQ-010 load_ack / load_err  output  1 / 1  one-cycle pulses; load accepted / load rejected.

Function
REQ-011 slow_clk SHALL pass through SYNC_STAGES flops; the last stage is sync_q.
REQ-012 An edge register prev_q SHALL hold sync_q of the previous cycle.
REQ-013 An armed flag SHALL be set on the first cycle sync_q=0 after reset and stay set.
REQ-014 tick SHALL assert for exactly one cycle when sync_q=1, prev_q=0 and armed=1.
REQ-015 Latency: a slow_clk 0->1 transition SHALL produce tick SYNC_STAGES+1 clk cycles later.
REQ-016 tick SHALL NOT repeat while slow_clk stays high; one tick per full slow_clk period.
REQ-017 On tick, seconds SHALL increment; 59 SHALL wrap to 0 and carry into minutes.
REQ-018 minutes SHALL wrap 59->0 with carry into hours; hours SHALL wrap 23->0.
REQ-019 All time registers SHALL update on the clock edge after the tick cycle.
REQ-020 day_wrap SHALL assert in the same cycle the registers become 00:00:00 through rollover.
REQ-021 A load SHALL be valid iff load_hr<=23, load_min<=59 and load_sec<=59.
REQ-022 Valid load: registers SHALL take the load values next cycle; load_ack SHALL pulse in that cycle.
REQ-023 Invalid load: time SHALL be unchanged; load_err SHALL pulse next cycle.
REQ-024 Load and tick in the same cycle: load SHALL win and the tick increment SHALL be discarded; tick output still pulses.
REQ-025 A load of 00:00:00 SHALL NOT assert day_wrap.
REQ-026 Registers SHALL never hold out-of-range values; out-of-range states SHALL be unreachable.

Reset
REQ-027 While rst=1: hours, minutes, seconds = 0; tick, day_wrap, load_ack, load_err = 0.
REQ-028 While rst=1: synchronizer flops, prev_q and armed SHALL be 0.
REQ-029 rst asserted mid-count or concurrent with load SHALL override everything; no pulse SHALL appear in the cycle after rst deasserts.
REQ-030 If slow_clk is high across reset release, no tick SHALL occur until slow_clk has gone low and high again.

Structure
REQ-031 Shared package: SEC_MAX=59, MIN_MAX=59, HR_MAX=23, and widths HR_W=5, MIN_W=6, SEC_W=6.
REQ-032 The synchronizer, armed flag and edge detector SHALL be one sub-module, tick_sync (ports clk, rst, async_in, pulse).
REQ-033 The counter chain and load logic SHALL stay in the top module; there SHALL be no other clock domain and no derived clocks.

Verification
REQ-034 Reset, then slow_clk 0->1 at cycle 10 with SYNC_STAGES=2 -> tick at cycle 13 only; seconds=1 at cycle 14.
REQ-035 Load 23:59:58, then 2 slow_clk periods -> 23:59:59, then 00:00:00 with day_wrap pulsing in the same cycle.
REQ-036 Load 12:60:00 -> load_err pulse; time unchanged; load_ack stays 0.
REQ-037 Load 05:06:07 in the same cycle as tick -> 05:06:07 next cycle; no increment applied; load_ack=1.
REQ-038 slow_clk held high through rst release -> no tick; the first tick follows the next 0->1 transition.
REQ-039 Apply 3600 slow_clk periods from 00:00:00 -> 01:00:00; exactly 3600 ticks counted; day_wrap never asserted.
